bootrom_fetch: RTL and testbench

Instruction fetch front-end that sits directly in front of the synchronous-read boot ROM. It drives the ROM word address, absorbs the ROM's fixed 1-cycle read latency in a 2-entry word buffer, and slices each ROM word into 32-bit RISC-V instructions. Instructions are delivered to decode over a valid/ready handshake with their byte PC. Decode can redirect the fetch stream to any in-ROM PC.

---
 rtl/bootrom_fetch.sv | 121 ++++++++++++
 tb/tb_bootrom_fetch.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/bootrom_fetch.sv
// Boot ROM fetch front-end: issues ROM word reads, buffers two returned words,
// and slices them into 32-bit instructions handed to decode with their byte PC.
module bootrom_fetch #(
    parameter int          ADDR_WIDTH = 8,
    parameter int          DATA_WIDTH = 64,
    parameter logic [63:0] RESET_PC   = 64'h0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_rdata,
    input  logic                  redirect_valid,
    input  logic [63:0]           redirect_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [31:0]           inst,
    output logic [63:0]           inst_pc,
    output logic                  fault
);

    localparam int LANES = DATA_WIDTH / 32;
    localparam int LW    = $clog2(LANES);
    localparam int LWS   = (LW > 0) ? LW : 1;
    localparam int OFF   = LW + 2;
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = '1;

    if (LANES < 1 || DATA_WIDTH != 32 * LANES || (LANES & (LANES - 1)) != 0) begin : g_bad_width
        $fatal(1, "bootrom_fetch: DATA_WIDTH must be 32 * a power of two");
    end
    if (RESET_PC[1:0] != 2'b00 || (RESET_PC >> (OFF + ADDR_WIDTH)) != 64'd0) begin : g_bad_reset_pc
        $fatal(1, "bootrom_fetch: RESET_PC must be aligned and inside the ROM");
    end

    function automatic logic in_range(input logic [63:0] pc);
        return (pc[1:0] == 2'b00) && ((pc >> (OFF + ADDR_WIDTH)) == 64'd0);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] word_of(input logic [63:0] pc);
        return pc[OFF +: ADDR_WIDTH];
    endfunction

    logic [ADDR_WIDTH-1:0] fetch_ptr;
    logic                  inflight_q;
    logic                  end_q;
    logic                  fault_q;
    logic [1:0]            cnt_q;
    logic [63:0]           pc_q;
    logic [DATA_WIDTH-1:0] fifo0_q, fifo1_q;

    logic [LWS-1:0] lane;
    logic           accept, pop, push, issue;
    logic [2:0]     occ;

    always_comb begin
        lane = '0;
        if (LW > 0) lane = pc_q[2 +: LWS];
    end

    assign rom_addr   = fetch_ptr;
    assign inst_pc    = pc_q;
    assign fault      = fault_q;
    assign inst_valid = (cnt_q != 2'd0) && !fault_q && !redirect_valid;
    assign inst       = fifo0_q[{lane, 5'b0} +: 32];

    assign accept = inst_valid && inst_ready;
    assign pop    = accept && (lane == LWS'(LANES - 1));
    assign push   = inflight_q && !redirect_valid;
    // Occupancy after this cycle's pop, counting the word still in flight.
    assign occ    = {1'b0, cnt_q} + {2'b0, inflight_q} - {2'b0, pop};
    assign issue  = !redirect_valid && !fault_q && !end_q && (occ < 3'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_ptr  <= word_of(RESET_PC);
            inflight_q <= 1'b0;
            end_q      <= 1'b0;
            fault_q    <= 1'b0;
            cnt_q      <= 2'd0;
            pc_q       <= RESET_PC;
        end else if (redirect_valid) begin
            inflight_q <= 1'b0;
            end_q      <= 1'b0;
            cnt_q      <= 2'd0;
            pc_q       <= redirect_pc;
            if (in_range(redirect_pc)) begin
                fetch_ptr <= word_of(redirect_pc);
                fault_q   <= 1'b0;
            end else begin
                fault_q   <= 1'b1;
            end
        end else begin
            inflight_q <= issue;
            if (issue) begin
                if (fetch_ptr == LAST_WORD) end_q <= 1'b1;
                else                        fetch_ptr <= fetch_ptr + ADDR_WIDTH'(1);
            end
            cnt_q <= 2'({1'b0, cnt_q} + {2'b0, push} - {2'b0, pop});
            if (accept) pc_q <= pc_q + 64'd4;
            // Consuming the final lane of the top word leaves nothing more to fetch.
            if (pop && end_q && word_of(pc_q) == LAST_WORD) fault_q <= 1'b1;
        end
    end

    // Word storage carries no reset; validity is tracked by cnt_q alone.
    always_ff @(posedge clk) begin
        if (push && pop) begin
            if (cnt_q == 2'd2) begin
                fifo0_q <= fifo1_q;
                fifo1_q <= rom_rdata;
            end else begin
                fifo0_q <= rom_rdata;
            end
        end else if (pop) begin
            fifo0_q <= fifo1_q;
        end else if (push) begin
            if (cnt_q == 2'd0) fifo0_q <= rom_rdata;
            else               fifo1_q <= rom_rdata;
        end
    end

endmodule

// File: tb/tb_bootrom_fetch.sv
// Bench for bootrom_fetch: directed scenarios plus a randomized stream checked
// against an instruction-stream reference model built on a ROM array.
module tb_bootrom_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rom_addr;
    logic [63:0] rom_rdata = 64'd0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'd0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        fault;

    logic [63:0] rom [256];
    int tests = 0;
    int fails = 0;

    bootrom_fetch #(.ADDR_WIDTH(8), .DATA_WIDTH(64), .RESET_PC(64'h0)) dut (
        .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .inst_pc(inst_pc), .fault(fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_rdata <= rom[rom_addr];

    function automatic logic [31:0] rom_inst(input logic [63:0] pc);
        logic [63:0] w;
        w = rom[pc[10:3]];
        return pc[2] ? w[63:32] : w[31:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Lands at posedge+1: inputs may be driven, then #1 before sampling.
    task automatic to_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_valid", inst_valid, 0);
        chk("rst_addr", rom_addr, 0);
        chk("rst_pc", inst_pc, 0);
        chk("rst_fault", fault, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic expect_inst(input string tag, input logic [63:0] pc);
        chk({tag, "_valid"}, inst_valid, 1);
        chk({tag, "_pc"}, inst_pc, pc);
        chk({tag, "_inst"}, inst, rom_inst(pc));
    endtask

    // Called at cycle 0 after reset release.
    task automatic run_basic();
        inst_ready = 1'b1;
        #1;
        chk("c0_valid", inst_valid, 0);
        chk("c0_addr", rom_addr, 0);
        to_cycle(); #1;
        chk("c1_valid", inst_valid, 0);
        for (int k = 0; k < 4; k++) begin
            to_cycle(); #1;
            chk("basic_valid", inst_valid, 1);
            chk("basic_pc", inst_pc, 64'(4 * k));
            chk("basic_inst", inst, 64'(32'hA + k));
        end
    endtask

    initial begin
        int accepts;
        logic [63:0] exp_pc;

        for (int i = 0; i < 256; i++) rom[i] = {$urandom, $urandom};
        rom[0] = {32'hB, 32'hA};
        rom[1] = {32'hD, 32'hC};

        // Reset and first stream
        do_reset();
        run_basic();

        // Misaligned and out-of-range redirects, then recovery
        to_cycle(); redirect_valid = 1'b1; redirect_pc = 64'h6; #1;
        chk("mis_redir_valid", inst_valid, 0);
        to_cycle(); redirect_valid = 1'b0; #1;
        chk("mis_fault", fault, 1);
        chk("mis_valid", inst_valid, 0);
        to_cycle(); redirect_valid = 1'b1; redirect_pc = 64'h800; #1;
        to_cycle(); redirect_valid = 1'b0; #1;
        chk("oor_fault", fault, 1);
        to_cycle(); #1;
        chk("oor_valid", inst_valid, 0);
        to_cycle(); redirect_valid = 1'b1; redirect_pc = 64'h0; #1;
        to_cycle(); redirect_valid = 1'b0; #1;
        chk("rec_fault", fault, 0);
        chk("rec_v1", inst_valid, 0);
        to_cycle(); #1;
        chk("rec_v2", inst_valid, 0);
        to_cycle(); #1;
        expect_inst("rec", 64'h0);

        // Backpressure
        do_reset();
        inst_ready = 1'b0;
        to_cycle(); to_cycle(); #1;
        for (int c = 2; c <= 9; c++) begin
            chk("bp_valid", inst_valid, 1);
            chk("bp_inst", inst, 32'hA);
            chk("bp_pc", inst_pc, 0);
            if (c >= 3) chk("bp_addr", rom_addr, 2);
            to_cycle(); #1;
        end
        inst_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            expect_inst("bp_rel", 64'(4 * k));
            to_cycle(); #1;
        end

        // Redirect while valid
        do_reset();
        inst_ready = 1'b1;
        repeat (4) to_cycle();
        redirect_valid = 1'b1; redirect_pc = 64'h14; #1;
        chk("rd_c4_valid", inst_valid, 0);
        to_cycle(); redirect_valid = 1'b0; #1;
        chk("rd_c5_valid", inst_valid, 0);
        to_cycle(); #1;
        chk("rd_c6_valid", inst_valid, 0);
        to_cycle(); #1;
        expect_inst("rd_c7", 64'h14);
        chk("rd_c7_lit", inst, rom[2][63:32]);
        to_cycle(); #1;
        expect_inst("rd_c8", 64'h18);
        chk("rd_c8_lit", inst, rom[3][31:0]);

        // Last ROM word and exhaustion
        to_cycle(); redirect_valid = 1'b1; redirect_pc = 64'h7F8; #1;
        to_cycle(); redirect_valid = 1'b0; #1;
        chk("end_addr", rom_addr, 8'hFF);
        to_cycle(); #1;
        chk("end_v2", inst_valid, 0);
        to_cycle(); #1;
        expect_inst("end_a", 64'h7F8);
        chk("end_a_fault", fault, 0);
        to_cycle(); #1;
        expect_inst("end_b", 64'h7FC);
        for (int k = 0; k < 2; k++) begin
            to_cycle(); #1;
            chk("exh_fault", fault, 1);
            chk("exh_valid", inst_valid, 0);
            chk("exh_addr", rom_addr, 8'hFF);
        end

        // Asynchronous reset mid-stream with two words buffered
        do_reset();
        inst_ready = 1'b0;
        repeat (4) to_cycle();
        #1;
        chk("ar_pre_valid", inst_valid, 1);
        chk("ar_pre_addr", rom_addr, 2);
        rst_n = 1'b0; #1;
        chk("ar_valid", inst_valid, 0);
        chk("ar_addr", rom_addr, 0);
        chk("ar_pc", inst_pc, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_basic();

        // Randomized stream with random backpressure and redirects
        do_reset();
        exp_pc = 64'h0;
        accepts = 0;
        for (int c = 0; c < 800; c++) begin
            if (c != 0) to_cycle();
            inst_ready = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 24) == 0) || (exp_pc > 64'h700);
            redirect_pc = 64'($urandom_range(0, 32'h5FF)) & ~64'h3;
            #1;
            chk("rnd_fault", fault, 0);
            if (redirect_valid) begin
                chk("rnd_redir_valid", inst_valid, 0);
                exp_pc = redirect_pc;
            end else if (inst_valid && inst_ready) begin
                chk("rnd_pc", inst_pc, exp_pc);
                chk("rnd_inst", inst, rom_inst(exp_pc));
                exp_pc = exp_pc + 64'd4;
                accepts++;
            end
        end
        chk("rnd_progress", accepts > 200, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
